ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage. It consumes the decoded operands and control from the ID/EX pipeline register. It stalls the front of the pipeline (IF, ID, ID/EX) while it iterates, then presents one result for the EX/MEM register to capture. The ALU handles all non-M operations; this block is active only when md_start is asserted.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
md_start  input  1  M-extension instruction valid in EX this cycle
md_op  input  3  RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
operand_a  input  XLEN  rs1 value (post-forwarding)
operand_b  input  XLEN  rs2 value (post-forwarding)
flush  input  1  abort current operation (branch/jump redirect)
md_stall  output  1  hold IF/ID/ID-EX; bubble EX/MEM
md_busy  output  1  state != IDLE
md_result  output  XLEN  result, valid only while md_result_valid
md_result_valid  output  1  one-cycle result strobe

Behaviour:
- Reset: state IDLE, iteration counter 0, internal operand/accumulator registers 0.
- Reset outputs: md_stall 0, md_busy 0, md_result 0, md_result_valid 0.
- Reset mid-operation: back to IDLE on that edge; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE, md_start=1, flush=0:
  - Latch md_op and |operand| values; record result sign.
  - Go to CALC with counter 0.
  - Fast path 1: div/rem with operand_b==0 goes straight to DONE. Quotient = all-ones; remainder = operand_a.
  - Fast path 2: DIV/REM with operand_a==0x80000000 and operand_b==0xFFFFFFFF goes straight to DONE. Quotient = 0x80000000; remainder = 0.
- CALC:
  - Multiply: one shift-add per cycle on a 2*XLEN product.
  - Divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
  - After XLEN iterations (counter == XLEN-1 at edge), go to DONE.
- DONE: md_result_valid=1 for exactly one cycle, then IDLE unconditionally.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: operand_a signed, operand_b unsigned.
  - DIV/REM: both operands signed.
  - Magnitudes are used internally and the result is negated at DONE when required.
  - Quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
- Result selection: MUL gives product[XLEN-1:0]; MULH/MULHSU/MULHU give product[2*XLEN-1:XLEN].
- md_result is registered. It holds its last value outside DONE; the bench checks it only with md_result_valid.
- Latency:
  - Normal: md_result_valid asserts XLEN+1 cycles after the accepting edge (33 for XLEN=32).
  - Fast paths: 1 cycle after the accepting edge.
- md_stall:
  - Combinational: (IDLE & md_start & ~flush) | CALC.
  - It is 0 in DONE, so the pipeline advances on the DONE edge and EX/MEM captures md_result.
- md_start while busy: ignored. The held upstream instruction is the same one and is not re-accepted.
- md_start and md_result_valid in the same cycle: the start is ignored. The stage advances, so any new start arrives after the return to IDLE.
- flush:
  - In any state, return to IDLE on the next edge; md_result_valid is suppressed.
  - flush with md_start in IDLE: nothing is accepted, md_stall=0.
- Operands are captured internally, so upstream changes during CALC have no effect.

Decomposition:
- Package ex_muldiv_pkg:
  - typedef enum logic [2:0] md_op_t, values as in the md_op encoding.
  - typedef enum logic [1:0] md_state_t {IDLE, CALC, DONE}.
  - Helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- No sub-module. Shift-add and restoring-divide datapaths share the accumulator register inside one module (~250 lines).

Test Plan:
- MUL 7 x 0xFFFFFFFD -> md_result 0xFFFFFFEB, md_result_valid exactly 33 cycles after start; md_stall high for cycles 0..32, low on the valid cycle.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each valid 1 cycle after start. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0, also 1 cycle.
- Start DIV, assert flush at CALC cycle 10 -> busy low next cycle, no md_result_valid. An immediate new MUL 3 x 4 -> 12 after 33 cycles.
- Assert reset at CALC cycle 5 -> all outputs 0 next cycle. Back-to-back starts across DONE -> exactly one md_result_valid per instruction.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
//   Shared types and operation-decode helpers for the iterative RV32M
//   multiply/divide unit.
//   - md_op_t    : RV32M funct3 encoding
//   - md_state_t : unit sequencing states
//   - is_div / is_signed_a / is_signed_b : operation classification
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic is_div(md_op_t op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(md_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(md_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. One
//   shift-add (multiply) or restoring step (divide) per cycle on a shared
//   2*XLEN accumulator, operating on operand magnitudes; the sign is applied
//   when the result is registered.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   md_start, md_op     : M-instruction valid in EX and its funct3
//   operand_a/operand_b : rs1/rs2 values (captured on acceptance)
//   flush               : abort any operation in progress
//   md_stall            : hold IF/ID/ID-EX while accepting or iterating
//   md_busy             : unit not idle
//   md_result           : registered result, meaningful with md_result_valid
//   md_result_valid     : one-cycle result strobe (DONE state)
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            md_stall,
  output logic            md_busy,
  output logic [XLEN-1:0] md_result,
  output logic            md_result_valid
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_reg, state_next;
  md_op_t            op_reg, op_next, op_in;
  logic              sa_reg, sa_next, sb_reg, sb_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [XLEN-1:0]   mag_reg, mag_next;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_reg, acc_next;      // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]   result_reg, result_next;

  logic              sa_in, sb_in;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] step_mul, step_div, step;

  // Apply signs to the final accumulator contents and select the result word.
  function automatic logic [XLEN-1:0] final_result(md_op_t op, logic sa, logic sb,
                                                    logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q, r;
    prod = (sa ^ sb) ? (2*XLEN)'(0) - acc : acc;
    q    = (sa ^ sb) ? XLEN'(0) - acc[XLEN-1:0] : acc[XLEN-1:0];
    r    = sa ? XLEN'(0) - acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:           return prod[XLEN-1:0];
      OP_DIV, OP_DIVU:  return q;
      OP_REM, OP_REMU:  return r;
      default:          return prod[2*XLEN-1:XLEN];
    endcase
  endfunction

  // Operand decode for acceptance.
  always_comb begin
    op_in = md_op_t'(md_op);
    sa_in = is_signed_a(op_in) & operand_a[XLEN-1];
    sb_in = is_signed_b(op_in) & operand_b[XLEN-1];
    abs_a = sa_in ? XLEN'(0) - operand_a : operand_a;
    abs_b = sb_in ? XLEN'(0) - operand_b : operand_b;
  end

  // One iteration of each datapath on the shared accumulator.
  always_comb begin
    // Multiply: lo holds the remaining multiplier bits; add into hi, shift right.
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mag_reg} : {(XLEN+1){1'b0}});
    step_mul = {mul_sum, acc_reg[XLEN-1:1]};
    // Divide: shifted remainder needs XLEN+1 bits before the trial subtract.
    div_diff = {1'b0, acc_reg[2*XLEN-1:XLEN-1]} - {2'b00, mag_reg};
    step_div = div_diff[XLEN+1] ? {acc_reg[2*XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    step     = is_div(op_reg) ? step_div : step_mul;
  end

  // Next-state and datapath control.
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    sa_next     = sa_reg;
    sb_next     = sb_reg;
    cnt_next    = cnt_reg;
    mag_next    = mag_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (md_start && !flush) begin
          op_next  = op_in;
          sa_next  = sa_in;
          sb_next  = sb_in;
          cnt_next = '0;
          if (is_div(op_in)) begin
            mag_next = abs_b;
            acc_next = {{XLEN{1'b0}}, abs_a};
          end else begin
            mag_next = abs_a;
            acc_next = {{XLEN{1'b0}}, abs_b};
          end
          if (is_div(op_in) && operand_b == '0) begin
            // Divide by zero: quotient all-ones, remainder is the dividend.
            state_next  = DONE;
            result_next = op_in[1] ? operand_a : '1;
          end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                       operand_a == MIN_INT && operand_b == '1) begin
            // Signed overflow: quotient MIN_INT, remainder 0.
            state_next  = DONE;
            result_next = op_in[1] ? '0 : MIN_INT;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          acc_next = step;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CW'(XLEN-1)) begin
            // Register the result on the final step so it is ready in DONE.
            state_next  = DONE;
            cnt_next    = '0;
            result_next = final_result(op_reg, sa_reg, sb_reg, step);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= OP_MUL;
      sa_reg     <= 1'b0;
      sb_reg     <= 1'b0;
      cnt_reg    <= '0;
      mag_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      sa_reg     <= sa_next;
      sb_reg     <= sb_next;
      cnt_reg    <= cnt_next;
      mag_reg    <= mag_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
    end
  end

  assign md_stall        = ((state_reg == IDLE) && md_start && !flush) || (state_reg == CALC);
  assign md_busy         = (state_reg != IDLE);
  assign md_result       = result_reg;
  assign md_result_valid = (state_reg == DONE) && !flush;

endmodule
